uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, meaning width of each stored byte.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of depth (DEPTH = 2**ADDR_WIDTH = 16).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_wr_en  input  1  write strobe, driven by Receiver o_rx_done.
REQ-006 SHALL have port i_wr_data  input  SIZE_DATA  byte to store, driven by Receiver o_rx_data.
REQ-007 SHALL have port i_rd_en  input  1  read request from consumer.
REQ-008 SHALL have port i_clr_ovr  input  1  clears sticky overrun flag.
REQ-009 SHALL have port o_rd_data  output  SIZE_DATA  registered read data.
REQ-010 SHALL have port o_rd_valid  output  1  one-cycle pulse: o_rd_data holds a newly read byte.
REQ-011 SHALL have port o_empty  output  1  FIFO holds zero entries.
REQ-012 SHALL have port o_full  output  1  FIFO holds DEPTH entries; drives Receiver i_fifo_full.
REQ-013 SHALL have port o_count  output  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH.
REQ-014 SHALL have port o_overrun  output  1  sticky: a write was dropped.

Function
REQ-015 Storage SHALL be DEPTH x SIZE_DATA memory with ADDR_WIDTH+1-bit write and read pointers; MSB distinguishes full from empty on wrap.
REQ-016 Write accepted (wr_ok) SHALL be i_wr_en & (!o_full | rd_ok); on wr_ok, i_wr_data stored at wr_ptr, wr_ptr increments mod 2**(ADDR_WIDTH+1).
REQ-017 Read accepted (rd_ok) SHALL be i_rd_en & !o_empty; on rd_ok, mem[rd_ptr] registered into o_rd_data, rd_ptr increments, o_rd_valid=1 next cycle.
REQ-018 Read latency SHALL be exactly 1 cycle from i_rd_en sampled high to o_rd_valid high; o_rd_data holds its value when no read is accepted.
REQ-019 i_rd_en while empty SHALL be ignored: no pointer change, o_rd_valid stays 0, even if i_wr_en is high same cycle (no write-through).
REQ-020 Simultaneous wr_ok and rd_ok SHALL leave o_count unchanged; full+read+write SHALL accept both and remain full.
REQ-021 o_count SHALL be wr_ptr - rd_ptr; o_empty = (o_count==0); o_full = (o_count==DEPTH); all three derived from registered pointers only (no combinational path from inputs).
REQ-022 i_wr_en while full with no rd_ok SHALL drop the byte, leave memory and pointers unchanged, and set o_overrun=1 next cycle.
REQ-023 o_overrun SHALL stay 1 until i_clr_ovr sampled high; if i_clr_ovr and a new overrun occur same cycle, overrun set wins.
REQ-024 Pointer wrap from 2**(ADDR_WIDTH+1)-1 to 0 SHALL be seamless; data order strictly first-in first-out across wraps.

Reset
REQ-025 On i_rst_n low, immediately and regardless of clock: pointers=0, o_count=0, o_empty=1, o_full=0, o_overrun=0, o_rd_valid=0, o_rd_data=0.
REQ-026 Reset mid-operation SHALL discard all stored bytes; memory contents need not be cleared.
REQ-027 First write SHALL be accepted on the first rising edge after i_rst_n deasserts.

Configuration
REQ-028 Macro UART_RX_FIFO_ALMOST_FULL_EN defined: SHALL add parameter AF_LEVEL (default 12) and output o_almost_full (1 bit) = (o_count >= AF_LEVEL), registered-pointer derived.
REQ-029 Macro undefined: o_almost_full and AF_LEVEL SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset, write 0x55 then read -> o_rd_valid pulse 1 cycle after i_rd_en, o_rd_data=0x55, o_empty=1 afterward.
REQ-031 Write 16 bytes 0x00..0x0F -> o_full=1, o_count=16; 17th write 0xAA -> o_overrun=1, read-out yields 0x00..0x0F in order, no 0xAA.
REQ-032 Full FIFO, i_wr_en and i_rd_en same cycle with 0x77 -> o_count stays 16, o_overrun stays 0, 0x77 read last.
REQ-033 Empty FIFO, i_rd_en and i_wr_en=0x33 same cycle -> no o_rd_valid, o_count=1; next read returns 0x33.
REQ-034 40 interleaved write/read cycles (pointer wrap twice) -> read sequence equals write sequence; then i_rst_n pulse with 5 entries -> o_count=0, o_empty=1 asynchronously.
REQ-035 With UART_RX_FIFO_ALMOST_FULL_EN, AF_LEVEL=12: 11 writes -> o_almost_full=0; 12th write -> o_almost_full=1; one read -> 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between the UART receiver and a consumer.
//
// The FIFO holds 2**ADDR_WIDTH bytes. Write and read pointers are ADDR_WIDTH+1 bits
// wide, and the extra MSB tells full from empty when the pointers wrap. A read is
// registered: o_rd_data and o_rd_valid update on the clock edge after i_rd_en is
// sampled with the FIFO non-empty. A write to a full FIFO with no read in the same
// cycle is dropped and sets the sticky o_overrun flag.
//
// Optional feature: define UART_RX_FIFO_ALMOST_FULL_EN to add parameter AF_LEVEL
// and output o_almost_full = (o_count >= AF_LEVEL).
//
// Ports:
//   i_clk          clock; all state changes on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_wr_en        write strobe (receiver o_rx_done)
//   i_wr_data      byte to store (receiver o_rx_data)
//   i_rd_en        read request from the consumer
//   i_clr_ovr      clears the sticky overrun flag
//   o_rd_data      registered read data, held between reads
//   o_rd_valid     one-cycle pulse: o_rd_data holds a newly read byte
//   o_empty        FIFO holds zero entries
//   o_full         FIFO holds DEPTH entries (receiver i_fifo_full)
//   o_count        number of stored entries, 0..DEPTH
//   o_overrun      sticky flag: a write was dropped
//   o_almost_full  (UART_RX_FIFO_ALMOST_FULL_EN only) o_count >= AF_LEVEL

module uart_rx_fifo #(
    parameter int unsigned SIZE_DATA  = 8,
    parameter int unsigned ADDR_WIDTH = 4
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    parameter int unsigned AF_LEVEL   = 12
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [SIZE_DATA-1:0]  i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_clr_ovr,
    output logic [SIZE_DATA-1:0]  o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    output logic                  o_almost_full
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [SIZE_DATA-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [SIZE_DATA-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 overrun_q, overrun_d;

    logic [PTR_W-1:0]     count;
    logic                 empty;
    logic                 full;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 wr_drop;

    // Occupancy comes from the registered pointers only, so it has no input path.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == PTR_W'(DEPTH));

    // A read frees a slot in the same cycle, so a full FIFO accepts a write with a read.
    // A read of an empty FIFO is ignored even if a write arrives in the same cycle.
    assign rd_ok   = i_rd_en & ~empty;
    assign wr_ok   = i_wr_en & (~full | rd_ok);
    assign wr_drop = i_wr_en & full & ~rd_ok;

    // Next-state logic for pointers, read port and overrun flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overrun_d  = overrun_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rd_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_valid_d = 1'b1;
        end

        // A new overrun takes priority over a clear in the same cycle.
        if (wr_drop) begin
            overrun_d = 1'b1;
        end else if (i_clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // Control and read-port registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Storage array. It is not reset, because resetting the pointers discards its contents.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_overrun  = overrun_q;
    assign o_count    = count;
    assign o_empty    = empty;
    assign o_full     = full;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    assign o_almost_full = (count >= PTR_W'(AF_LEVEL));
`endif

endmodule
